// File: rtl/prbs_gen_mc.sv
// prbs_gen_mc: multi-channel parallel PRBS generator, one REMAINDER_SIZE-bit LFSR per channel
// Ports:
//   clk, reset (async active-high)
//   en                         run enable; dropping it drains the pending word
//   seed_load/seed_all/seed_ch/seed_in  runtime seeding of one or all channels
//   out_valid/out_ready/datout          word stream, channel c at [c*BIT_COUNT +: BIT_COUNT]
//   zero_seed_err              sticky, an all-zero seed was replaced by DEFAULT_SEED
//   word_cnt                   saturating accept counter, present only with PRBS_GEN_CNT_EN
module prbs_gen_mc #(
    parameter int NUM_CH = 2,
    parameter int BIT_COUNT = 16,
    parameter int REMAINDER_SIZE = 11,
    parameter logic [REMAINDER_SIZE:0] CRC_POLYNOMIAL = 12'b1010_0000_0001,
    parameter logic [REMAINDER_SIZE-1:0] DEFAULT_SEED = 11'h001,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        seed_load,
    input  logic                        seed_all,
    input  logic [CHW-1:0]              seed_ch,
    input  logic [REMAINDER_SIZE-1:0]   seed_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CH*BIT_COUNT-1:0] datout,
    output logic                        zero_seed_err
`ifdef PRBS_GEN_CNT_EN
    ,
    output logic [31:0]                 word_cnt
`endif
);
    localparam int R = REMAINDER_SIZE;
    localparam logic [R-1:0] TAPS = CRC_POLYNOMIAL[R:1];
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;
    logic [R-1:0] lfsr [NUM_CH];
    logic [R-1:0] nxt_lfsr [NUM_CH];
    logic [NUM_CH*BIT_COUNT-1:0] nxt_word;
    logic [NUM_CH-1:0] hit;
    logic seed_ok, accept, load;
    logic [R-1:0] seed_val;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_hit
        assign hit[c] = seed_all | (seed_ch == CHW'(c));
    end
    // an out-of-range seed_ch hits no channel, so the strobe is ignored entirely
    assign seed_ok = seed_load & (|hit);
    assign seed_val = (seed_in == '0) ? DEFAULT_SEED : seed_in;
    assign accept = out_valid & out_ready;
    assign load = en & ((state == IDLE) | accept);
    always_comb begin : step
        logic [R-1:0] s;
        logic fb;
        nxt_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s = lfsr[c];
            for (int i = 0; i < BIT_COUNT; i++) begin
                fb = ^(TAPS & s);
                nxt_word[c*BIT_COUNT + i] = fb;
                s = {s[R-2:0], fb};
            end
            nxt_lfsr[c] = s;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) lfsr[c] <= DEFAULT_SEED;
            datout <= '0;
            out_valid <= 1'b0;
            zero_seed_err <= 1'b0;
            state <= IDLE;
        end else if (seed_ok) begin
            // reseeding discards any pending word; with en high the next edge loads from the new seed
            for (int c = 0; c < NUM_CH; c++) if (hit[c]) lfsr[c] <= seed_val;
            if (seed_in == '0) zero_seed_err <= 1'b1;
            out_valid <= 1'b0;
            state <= IDLE;
        end else begin
            if (load) begin
                datout <= nxt_word;
                for (int c = 0; c < NUM_CH; c++) lfsr[c] <= nxt_lfsr[c];
            end
            out_valid <= load | (out_valid & ~accept);
            state <= load ? RUN : (out_valid & ~accept) ? (en ? RUN : DRAIN) : IDLE;
        end
    end
`ifdef PRBS_GEN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_cnt <= '0;
        else if (seed_ok) word_cnt <= '0;
        else if (accept && word_cnt != 32'hFFFF_FFFF) word_cnt <= word_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_prbs_gen_mc.sv
// tb_prbs_gen_mc: scoreboard bench for prbs_gen_mc (NUM_CH=2, BIT_COUNT=16, R=11)
module tb_prbs_gen_mc;
    logic clk, reset, en, seed_load, seed_all, out_valid, out_ready, zero_seed_err;
    logic [0:0] seed_ch;
    logic [10:0] seed_in;
    logic [31:0] datout;
`ifdef PRBS_GEN_CNT_EN
    logic [31:0] word_cnt;
`endif
    int n_tests = 0, n_fail = 0, acc_cnt = 0;
    logic [31:0] q [$];
    logic [10:0] m0, m1;

    prbs_gen_mc dut (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_all(seed_all),
        .seed_ch(seed_ch), .seed_in(seed_in), .out_valid(out_valid), .out_ready(out_ready),
        .datout(datout), .zero_seed_err(zero_seed_err)
`ifdef PRBS_GEN_CNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // reference step: taps x11+x9 -> feedback s[10]^s[8], returns {next_state, word}
    function automatic logic [26:0] mstep(input logic [10:0] s0);
        logic [10:0] s;
        logic [15:0] w;
        logic f;
        s = s0;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            f = s[10] ^ s[8];
            w[i] = f;
            s = {s[9:0], f};
        end
        return {s, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // h0/h1: first word of that channel is the hand-computed DEFAULT_SEED word 16'h0500
    task automatic push_n(input int n, input bit h0, input bit h1);
        logic [26:0] r0, r1;
        logic [15:0] w0, w1;
        for (int k = 0; k < n; k++) begin
            r0 = mstep(m0);
            r1 = mstep(m1);
            m0 = r0[26:16];
            m1 = r1[26:16];
            w0 = (k == 0 && h0) ? 16'h0500 : r0[15:0];
            w1 = (k == 0 && h1) ? 16'h0500 : r1[15:0];
            q.push_back({w1, w0});
        end
    endtask

    // runs exactly n (>=2) words from IDLE back to IDLE; tog gives 3-low/1-high ready
    task automatic run_words(input int n, input bit h0, input bit h1, input bit tog);
        int start, cyc;
        push_n(n, h0, h1);
        start = acc_cnt;
        cyc = 0;
        en = 1'b1;
        while (acc_cnt < start + n - 1 && cyc < 4 * n + 40) begin
            out_ready = tog ? (cyc % 4 == 3) : 1'b1;
            tick();
            cyc++;
        end
        en = 1'b0;
        while ((out_valid || acc_cnt != start + n) && cyc < 4 * n + 80) begin
            out_ready = tog ? (cyc % 4 == 3) : 1'b1;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        chk("run_accepts", 32'(acc_cnt - start), 32'(n));
    endtask

    task automatic seed(input bit all, input logic [0:0] ch, input logic [10:0] v);
        seed_load = 1'b1;
        seed_all = all;
        seed_ch = ch;
        seed_in = v;
        tick();
        seed_load = 1'b0;
        seed_all = 1'b0;
        seed_in = '0;
    endtask

    // monitor: pops one expected word per accept, checks words hold while stalled
    initial begin
        logic stall_prev;
        logic [31:0] hold;
        stall_prev = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (stall_prev && out_valid) chk("stall_hold", datout, hold);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL word_extra: got %h with nothing expected", datout);
                    end else chk("word", datout, q.pop_front());
                    acc_cnt++;
                end
                stall_prev = out_valid && !out_ready;
                hold = datout;
            end
        end
    end

    initial begin
        logic [26:0] r;
        reset = 1'b1;
        en = 1'b0;
        seed_load = 1'b0;
        seed_all = 1'b0;
        seed_ch = '0;
        seed_in = '0;
        out_ready = 1'b1;
        m0 = 11'h001;
        m1 = 11'h001;
        repeat (3) tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_datout", datout, 32'd0);
        chk("reset_err", 32'(zero_seed_err), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_no_word", 32'(out_valid), 32'd0);
        // long free run, both channels from the default seed
        run_words(1000, 1'b1, 1'b1, 1'b0);
`ifdef PRBS_GEN_CNT_EN
        chk("word_cnt_run", word_cnt, 32'd1000);
`endif
        // reseed only channel 1; channel 0 continues
        seed(1'b0, 1'b1, 11'h001);
        m1 = 11'h001;
        run_words(8, 1'b0, 1'b1, 1'b0);
        // zero seed on channel 0 is replaced by the default seed
        seed(1'b0, 1'b0, 11'h000);
        m0 = 11'h001;
        chk("zero_err_set", 32'(zero_seed_err), 32'd1);
        run_words(4, 1'b1, 1'b0, 1'b0);
        // stalling sink with drain at the end
        run_words(20, 1'b0, 1'b0, 1'b1);
        // pending word discarded by a reseed, reload one cycle later
        en = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("stall_valid", 32'(out_valid), 32'd1);
        repeat (2) tick();
        seed_load = 1'b1;
        seed_all = 1'b1;
        seed_in = 11'h2AB;
        tick();
        seed_load = 1'b0;
        seed_all = 1'b0;
        chk("discard_valid", 32'(out_valid), 32'd0);
        tick();
        r = mstep(11'h2AB);
        chk("reseed_valid", 32'(out_valid), 32'd1);
        chk("reseed_word", datout, {r[15:0], r[15:0]});
        en = 1'b0;
        seed(1'b1, 1'b0, 11'h001);
        chk("discard2_valid", 32'(out_valid), 32'd0);
        tick();
        chk("idle_after_seed", 32'(out_valid), 32'd0);
        m0 = 11'h001;
        m1 = 11'h001;
        run_words(3, 1'b1, 1'b1, 1'b0);
        chk("zero_err_sticky", 32'(zero_seed_err), 32'd1);
        // asynchronous reset mid-stream
        push_n(10, 1'b0, 1'b0);
        en = 1'b1;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_datout", datout, 32'd0);
        chk("async_err", 32'(zero_seed_err), 32'd0);
`ifdef PRBS_GEN_CNT_EN
        chk("word_cnt_reset", word_cnt, 32'd0);
`endif
        q.delete();
        en = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        m0 = 11'h001;
        m1 = 11'h001;
        tick();
        run_words(3, 1'b1, 1'b1, 1'b0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
